// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data cache-port arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int CNT_W           = 8;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    ABORT  = 2'b11
  } arb_state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cache_req_t;

  function automatic side_e side_of(input logic is_d);
    return is_d ? SIDE_D : SIDE_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and cache-controller signals of the arbiter; slave = arbiter, master = environment.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              i_rd;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_data_out;
  logic              i_hit;
  logic              i_err;

  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data_in;
  logic              d_done;
  logic [DATA_W-1:0] d_data_out;
  logic              d_hit;
  logic              d_err;

  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data_in;
  logic              c_rd;
  logic              c_wr;
  logic              c_done;
  logic [DATA_W-1:0] c_data_out;
  logic              c_hit;
  logic              c_err;

  modport slave (
    input  i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in,
    input  c_done, c_data_out, c_hit, c_err,
    output i_done, i_data_out, i_hit, i_err,
    output d_done, d_data_out, d_hit, d_err,
    output c_addr, c_data_in, c_rd, c_wr
  );

  modport master (
    output i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in,
    output c_done, c_data_out, c_hit, c_err,
    input  i_done, i_data_out, i_hit, i_err,
    input  d_done, d_data_out, d_hit, d_err,
    input  c_addr, c_data_in, c_rd, c_wr
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Wait-cycle counter for an outstanding cache access; expire flags the last allowed cycle.
module mem_arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (load)  cnt <= '0;
    else if (count) cnt <= cnt + 1'b1;
  end

  assign expire = count & (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requesters onto a single cache controller port.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; default build gives data side priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  arb_state_e state, state_nxt;
  side_e      owner;
  cache_req_t held, idle_req, cur;
  logic       d_bad, i_req, d_req, win_d, win_i, grant;
  logic       latch, tmr_load, tmr_count, expire;
  logic       rsp_en, rsp_done, rsp_err;
  side_e      rsp_side;

  // A data request with both rd and wr set is rejected and never competes.
  assign d_bad = bus.d_rd & bus.d_wr;
  assign i_req = bus.i_rd;
  assign d_req = (bus.d_rd | bus.d_wr) & ~d_bad;

`ifdef MEM_ARBITER_RR_EN
  side_e last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       last <= SIDE_I;
    else if (state == IDLE && grant) last <= side_of(win_d);
  end

  assign win_d = d_req & (~i_req | (last == SIDE_I));
`else
  assign win_d = d_req;
`endif

  assign win_i = i_req & ~win_d;
  assign grant = win_i | win_d;

  always_comb begin
    idle_req = '0;
    if (win_d)
      idle_req = '{rd: bus.d_rd, wr: bus.d_wr, addr: bus.d_addr, data: bus.d_data_in};
    else if (win_i)
      idle_req = '{rd: 1'b1, wr: 1'b0, addr: bus.i_addr, data: 16'd0};
  end

  always_comb begin
    state_nxt = state;
    cur       = '0;
    latch     = 1'b0;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    rsp_en    = 1'b0;
    rsp_done  = 1'b0;
    rsp_err   = 1'b0;
    rsp_side  = SIDE_I;
    case (state)
      IDLE: begin
        if (grant) begin
          cur      = idle_req;
          rsp_side = side_of(win_d);
          if (bus.c_done | bus.c_err) begin
            rsp_en   = 1'b1;
            rsp_done = bus.c_done;
            rsp_err  = bus.c_err;
          end else begin
            latch     = 1'b1;
            tmr_load  = 1'b1;
            state_nxt = win_d ? BUSY_D : BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        cur       = held;
        rsp_side  = owner;
        tmr_count = 1'b1;
        if (bus.c_done | bus.c_err) begin
          rsp_en    = 1'b1;
          rsp_done  = bus.c_done;
          rsp_err   = bus.c_err;
          state_nxt = IDLE;
        end else if (expire) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        rsp_side  = owner;
        rsp_en    = 1'b1;
        rsp_err   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-wait hits pass inputs straight through, so outputs are forced low while in reset.
  always_comb begin
    bus.c_rd       = 1'b0;
    bus.c_wr       = 1'b0;
    bus.c_addr     = '0;
    bus.c_data_in  = '0;
    bus.i_done     = 1'b0;
    bus.i_err      = 1'b0;
    bus.i_hit      = 1'b0;
    bus.i_data_out = '0;
    bus.d_done     = 1'b0;
    bus.d_err      = 1'b0;
    bus.d_hit      = 1'b0;
    bus.d_data_out = '0;
    if (rst) begin
      bus.c_rd      = cur.rd;
      bus.c_wr      = cur.wr & ~cur.rd;
      bus.c_addr    = cur.addr;
      bus.c_data_in = cur.data;
      if (rsp_en && rsp_side == SIDE_I) begin
        bus.i_done = rsp_done;
        bus.i_err  = rsp_err;
        if (rsp_done) begin
          bus.i_data_out = bus.c_data_out;
          bus.i_hit      = bus.c_hit;
        end
      end
      if (rsp_en && rsp_side == SIDE_D) begin
        bus.d_done = rsp_done;
        bus.d_err  = rsp_err;
        if (rsp_done) begin
          bus.d_data_out = bus.c_data_out;
          bus.d_hit      = bus.c_hit;
        end
      end
      if (d_bad) bus.d_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= SIDE_I;
      held  <= '0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        held  <= idle_req;
        owner <= side_of(win_d);
      end
    end
  end

  mem_arb_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .count  (tmr_count),
    .expire (expire)
  );

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-side requester drivers, a latency-programmable cache model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 8;

  typedef struct packed {
    logic        done;
    logic        err;
    logic        hit;
    logic [15:0] data;
  } rsp_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        abort;
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   lat   = 0;
  logic err_inj = 1'b0;
  int   wcnt  = 0;

  cmd_t cq_i[$], cq_d[$];
  rsp_t eq_i[$], eq_d[$];
  byte  order_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cache controller model: answers after lat wait cycles, data = addr ^ 5A5A.
  logic c_act;
  assign c_act = bus.c_rd | bus.c_wr;
  always_comb begin
    bus.c_done     = c_act && (wcnt == lat);
    bus.c_err      = c_act && err_inj && (wcnt == lat);
    bus.c_hit      = c_act && (lat == 0);
    bus.c_data_out = c_act ? (bus.c_addr ^ 16'h5A5A) : 16'h0;
  end
  always @(posedge clk) wcnt <= (c_act && !bus.c_done) ? wcnt + 1 : 0;

  function automatic cmd_t mk(input logic rd, input logic wr, input logic abort,
                              input logic [15:0] addr, input logic [15:0] data);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.abort = abort; c.addr = addr; c.data = data;
    return c;
  endfunction

  function automatic rsp_t exp_of(input cmd_t c);
    rsp_t r;
    if ((c.rd && c.wr) || c.abort) r = {1'b0, 1'b1, 1'b0, 16'h0};
    else                           r = {1'b1, err_inj, (lat == 0), c.addr ^ 16'h5A5A};
    return r;
  endfunction

  task automatic put_req(input bit side, input cmd_t c);
    if (side) begin
      bus.d_rd = c.rd; bus.d_wr = c.wr; bus.d_addr = c.addr; bus.d_data_in = c.data;
      eq_d.push_back(exp_of(c));
    end else begin
      bus.i_rd = 1'b1; bus.i_addr = c.addr;
      eq_i.push_back(exp_of(c));
    end
  endtask

  task automatic drive(input bit side);
    cmd_t c;
    int   st;
    int   n;
    forever begin
      @(posedge clk); #1;
      if (rst && (side ? cq_d.size() : cq_i.size()) != 0) begin
        if (side) c = cq_d.pop_front(); else c = cq_i.pop_front();
        st = 1;
        while (st == 1) begin
          put_req(side, c);
          st = 2;
          n  = 0;
          while (st == 2 && n < 300) begin
            @(negedge clk or negedge rst);
            if (!rst) st = 1;
            else if (side ? (bus.d_done | bus.d_err) : (bus.i_done | bus.i_err)) st = 0;
            n++;
          end
          if (st == 2) chk(side ? "d_wait" : "i_wait", n, 0);
          // Request stays asserted through reset and is re-issued once it lifts.
          if (st == 1) begin
            wait (rst === 1'b1);
            @(posedge clk); #1;
          end
        end
      end else if (side) begin
        bus.d_rd = 1'b0; bus.d_wr = 1'b0;
      end else begin
        bus.i_rd = 1'b0;
      end
    end
  endtask

  initial drive(1'b0);
  initial drive(1'b1);

  always @(negedge clk) begin
    if (bus.i_done || bus.i_err) begin
      if (bus.i_done) order_log.push_back("I");
      if (eq_i.size() == 0) chk("i_unexp", eq_i.size(), 1);
      else chk("i_rsp", {bus.i_done, bus.i_err, bus.i_hit, bus.i_data_out}, eq_i.pop_front());
    end else chk("i_quiet", {bus.i_hit, bus.i_data_out}, 0);
    if (bus.d_done || bus.d_err) begin
      if (bus.d_done) order_log.push_back("D");
      if (eq_d.size() == 0) chk("d_unexp", eq_d.size(), 1);
      else chk("d_rsp", {bus.d_done, bus.d_err, bus.d_hit, bus.d_data_out}, eq_d.pop_front());
    end else chk("d_quiet", {bus.d_hit, bus.d_data_out}, 0);
    chk("c_excl", bus.c_rd & bus.c_wr, 0);
  end

  task automatic drain(input string tag);
    int n = 0;
    while ((cq_i.size() + cq_d.size() + eq_i.size() + eq_d.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n < 300), 1'b1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic miss_run(input string tag, input logic [15:0] addr, input int explen, input bit add_i);
    int nb = 0;
    int k  = 0;
    bit seen = 0;
    @(posedge clk); #2;
    while (k < 40 && !seen) begin
      @(negedge clk);
      if (add_i && k == 2) cq_i.push_back(mk(1, 0, 0, 16'h0600, 16'h0));
      if (busy) nb++;
      if (bus.c_rd | bus.c_wr) chk({tag, "_caddr"}, bus.c_addr, addr);
      if (bus.d_done | bus.d_err) begin
        seen = 1;
        if (!bus.d_done) chk({tag, "_abort_c"}, {bus.c_rd, bus.c_wr}, 2'b00);
      end
      k++;
    end
    chk({tag, "_len"}, nb, explen);
    @(negedge clk);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    string es;
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    string es;
    bus.i_rd = 0; bus.i_addr = 0;
    bus.d_rd = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_data_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_c", {bus.c_rd, bus.c_wr, bus.c_addr, bus.c_data_in}, 0);
    chk("rst_outs", {bus.i_done, bus.i_err, bus.d_done, bus.d_err}, 0);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_c", {bus.c_rd, bus.c_wr}, 0);

    // Tie of i read and d write from reset: data side wins in both policies.
    lat = 2;
    order_log.delete();
    cq_d.push_back(mk(0, 1, 0, 16'h0100, 16'h1234));
    cq_i.push_back(mk(1, 0, 0, 16'h0040, 16'h0));
    @(posedge clk); #2;
    chk("tie_cwr", {bus.c_rd, bus.c_wr}, 2'b01);
    chk("tie_caddr", bus.c_addr, 16'h0100);
    chk("tie_cdata", bus.c_data_in, 16'h1234);
    drain("tie_drain");
    chk("tie_ord0", order_log.size() > 0 ? order_log[0] : 8'h0, "D");
    chk("tie_ord1", order_log.size() > 1 ? order_log[1] : 8'h0, "I");

    // Back-to-back zero-wait hits from both sides.
    lat = 0;
    order_log.delete();
    cq_d.push_back(mk(1, 0, 0, 16'h0300, 16'h0));
    cq_d.push_back(mk(1, 0, 0, 16'h0302, 16'h0));
    cq_i.push_back(mk(1, 0, 0, 16'h0400, 16'h0));
    cq_i.push_back(mk(1, 0, 0, 16'h0402, 16'h0));
`ifdef MEM_ARBITER_RR_EN
    es = "DIDI";
`else
    es = "DDII";
`endif
    drain("alt_drain");
    for (int k = 0; k < 4; k++)
      chk("alt_ord", k < order_log.size() ? order_log[k] : 8'h0, es[k]);

    // Single zero-wait instruction hit.
    cq_i.push_back(mk(1, 0, 0, 16'h0040, 16'h0));
    @(posedge clk); #2;
    chk("hit_c", {bus.c_rd, bus.c_wr, bus.c_addr, bus.c_data_in}, {2'b10, 16'h0040, 16'h0});
    chk("hit_data", {bus.i_done, bus.i_data_out}, {1'b1, 16'h0040 ^ 16'h5A5A});
    @(negedge clk); chk("hit_busy", busy, 0);
    drain("hit_drain");

    // Miss with i request arriving while the data access is outstanding.
    lat = TO - 1;
    order_log.delete();
    cq_d.push_back(mk(1, 0, 0, 16'h0500, 16'h0));
    miss_run("miss", 16'h0500, TO - 1, 1'b1);
    drain("miss_drain");
    chk("miss_ord", order_log.size() > 1 ? {order_log[0], order_log[1]} : 16'h0, {"D", "I"});

    // c_done on the final allowed cycle still completes.
    lat = TO;
    cq_d.push_back(mk(1, 0, 0, 16'h0700, 16'h0));
    miss_run("edge", 16'h0700, TO, 1'b0);
    drain("edge_drain");

    // No c_done at all: abort after TO busy cycles plus the abort cycle.
    lat = 255;
    cq_d.push_back(mk(1, 0, 1, 16'h0800, 16'h0));
    miss_run("abort", 16'h0800, TO + 1, 1'b0);
    drain("abort_drain");

    // Cache error alongside completion, on a miss and on a zero-wait hit.
    lat = 2; err_inj = 1'b1;
    cq_d.push_back(mk(0, 1, 0, 16'h0900, 16'h5555));
    drain("cerr_d_drain");
    lat = 0;
    cq_i.push_back(mk(1, 0, 0, 16'h0A00, 16'h0));
    drain("cerr_i_drain");
    err_inj = 1'b0;

    // Illegal rd+wr on the data side, alone and with an i request.
    cq_d.push_back(mk(1, 1, 0, 16'h0B00, 16'h0));
    @(posedge clk); #2;
    chk("bad_c", {bus.c_rd, bus.c_wr}, 2'b00);
    drain("bad_drain");
    cq_d.push_back(mk(1, 1, 0, 16'h0B00, 16'h0));
    cq_i.push_back(mk(1, 0, 0, 16'h0C00, 16'h0));
    @(posedge clk); #2;
    chk("bad_i_c", {bus.c_rd, bus.c_wr}, 2'b10);
    chk("bad_i_addr", bus.c_addr, 16'h0C00);
    drain("bad_i_drain");

    // Reset in the middle of an instruction miss.
    lat = 255;
    cq_i.push_back(mk(1, 0, 0, 16'h0D00, 16'h0));
    @(posedge clk); #2;
    repeat (3) @(posedge clk);
    chk("mid_busy_pre", busy, 1);
    #3 rst = 1'b0;
    eq_i.delete(); eq_d.delete();
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_c", {bus.c_rd, bus.c_wr, bus.c_addr}, 0);
    chk("mid_rst_i", {bus.i_done, bus.i_err}, 0);
    @(negedge clk);
    chk("mid_rst_hold", {busy, bus.c_rd, bus.i_done, bus.i_err}, 0);
    lat = 2;
    @(posedge clk); #2 rst = 1'b1;
    drain("mid_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, max cycles a granted access may wait for c_done before abort (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 i_rd  input  1  instruction-side read request; i_addr input 16 word-aligned address.
REQ-005 d_rd, d_wr  input  1 each  data-side read/write requests; d_addr input 16; d_data_in input 16.
REQ-006 i_done, d_done  output  1 each  one-cycle completion pulse to the requester; i_data_out, d_data_out output 16; i_hit, d_hit output 1; i_err, d_err output 1.
REQ-007 c_addr output 16, c_data_in output 16, c_rd output 1, c_wr output 1: request to the shared cache controller.
REQ-008 c_done input 1, c_data_out input 16, c_hit input 1, c_err input 1: response from the shared cache controller.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-010 FSM states: IDLE, BUSY_I, BUSY_D, ABORT; encoding 2 bits, IDLE = 2'b00.
REQ-011 Requesters hold request and operands stable until their done or err pulse.
REQ-012 IDLE: winner selected combinationally; winner's addr/data/rd/wr driven on c_* in the same cycle.
REQ-013 IDLE with c_done=1 in that cycle (cache hit): winner's done pulse and data/hit driven same cycle; FSM stays IDLE (zero-wait hit).
REQ-014 IDLE with request and c_done=0: winner's addr/data/rd/wr latched; FSM -> BUSY_I or BUSY_D next edge.
REQ-015 BUSY_x: c_* driven from latched values; loser request ignored; c_done=1 -> done pulse to owner, FSM -> IDLE.
REQ-016 Timeout counter (8 bits) clears on entry to BUSY_x, increments each BUSY cycle; reaching TIMEOUT_CYC-1 without c_done -> FSM -> ABORT.
REQ-017 ABORT: c_rd=c_wr=0, owner's err pulses one cycle, FSM -> IDLE next edge.
REQ-018 c_err=1 in any cycle with a grant active -> owner's err asserted that cycle, with done if c_done also asserted.
REQ-019 d_rd and d_wr both high: d_err pulses one cycle; request not forwarded; i-side may be granted same cycle.
REQ-020 Simultaneous i and d requests in IDLE: winner per REQ-029/REQ-030; loser waits, served no earlier than the cycle after the winner's done.
REQ-021 Non-granted requester outputs: done=0, err=0, data_out=16'd0, hit=0.
REQ-022 i-side always issues read only; c_data_in=16'd0 on i grants.
REQ-023 c_rd, c_wr never both 1; both 0 when no grant.

Reset
REQ-024 rst low: FSM -> IDLE, latches, counter and RR pointer cleared asynchronously.
REQ-025 During and after reset, until first request: all outputs 0, busy=0.
REQ-026 Reset mid-BUSY aborts silently: no done/err pulse; requester re-issues.

Configuration
REQ-027 Macro MEM_ARBITER_RR_EN selects the arbitration policy.
REQ-028 Policy switch affects only winner selection; all other behaviour identical.
REQ-029 Without MEM_ARBITER_RR_EN: fixed priority, data side wins every tie.
REQ-030 With MEM_ARBITER_RR_EN: 1-bit last-grant pointer; tie goes to the side not last granted; pointer updates on every grant, reset value = instruction last (data wins first tie).

Structure
REQ-031 Shared package holds state encoding constants, TIMEOUT_CYC default, counter width.
REQ-032 One sub-module natural: mem_arb_timer (load/count/expire), instanced once.

Verification
REQ-033 i_rd=1, i_addr=16'h0040, c_done=1 same cycle, c_data_out=16'hBEEF -> i_done=1, i_data_out=16'hBEEF same cycle, FSM stays IDLE.
REQ-034 i_rd=1 and d_wr=1 (d_addr=16'h0100, d_data_in=16'h1234) together, no RR -> c_wr=1, c_addr=16'h0100; i served next grant; repeated tie with RR_EN -> grants alternate D, I, D.
REQ-035 d_rd=1 miss, c_done after 12 cycles -> busy high 12 cycles, c_addr held; d_done pulse on cycle 12; i_rd asserted meanwhile not forwarded.
REQ-036 d_rd=1, c_done never, TIMEOUT_CYC=8 -> ABORT after 8 BUSY cycles, d_err one-cycle pulse, IDLE next.
REQ-037 d_rd=d_wr=1 -> d_err pulse, c_rd=c_wr=0.
REQ-038 rst low during BUSY_I -> outputs 0 immediately, no i_done; new i_rd after release -> served normally.
